tof_bram_write_arbiter: RTL
===========================

Name: tof_bram_write_arbiter

Overview:
- Round-robin scheduler that shares the single ToF_BRAM write port between the 8 I2C ToF channels.
- Latches per-sensor ready strobes, drives ToF_Index to select the I2C module's muxed data_out, and issues one write per grant at {ToF_Index, zone}.
- Flags overruns and emits a frame-complete pulse once every sensor has written its last zone.
- Replaces the fixed-order memory-write FSM between the I2C comm modules and the BRAM.

Parameters:
- NUM_TOF, 8, number of sensor channels (power of 2).
- IDX_W, 3, log2(NUM_TOF); ToF_Index width.
- ZONE_W, 6, zone-address width carried in data_in[DATA_W+ZONE_W-1:DATA_W].
- DATA_W, 16, distance-sample width.
- LAST_ZONE, 63, zone number that marks a sensor's final result of a frame.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- en  in  1  grant enable; when 0, no new grants (requests still latched).
- ToF_dr  in  NUM_TOF  per-sensor ready strobe, 1-cycle pulse, bit i = sensor i.
- data_in  in  ZONE_W+DATA_W  muxed I2C result for the sensor selected by ToF_Index; valid the cycle after ToF_Index changes.
- clear_overrun  in  1  1-cycle pulse, clears all overrun bits.
- ToF_Index  out  IDX_W  registered sensor select.
- wea  out  1  BRAM write enable, 1-cycle pulse per grant.
- addra  out  IDX_W+ZONE_W  {ToF_Index, data_in zone}.
- dina  out  DATA_W  data_in[DATA_W-1:0].
- busy  out  1  high when state != IDLE.
- overrun  out  NUM_TOF  sticky per-sensor lost-sample flags.
- frame_done  out  1  1-cycle pulse, all sensors delivered LAST_ZONE.

Behaviour:
- Reset (reset==0 at a clk edge):
  - Outputs: ToF_Index=0, wea=0, addra=0, dina=0, busy=0, overrun=0, frame_done=0.
  - Internal: pending=0, done_mask=0, last_grant=NUM_TOF-1 (sensor 0 has first priority), state=IDLE.
  - Reset mid-transaction aborts it: no wea is issued and pending requests are lost.
- Request latch, every cycle:
  - pending[i] <= (pending[i] & ~clr[i]) | ToF_dr[i], where clr[i] is the grant clear. Set wins over clear in the same cycle.
  - overrun[i] is set when ToF_dr[i]=1 while pending[i]=1 and pending[i] is not being cleared that cycle.
  - clear_overrun zeroes overrun; a simultaneous new overrun event wins.
- FSM, states IDLE, SELECT, WRITE:
  - IDLE:
    - If en=1 and pending!=0, grant g = first set bit searching last_grant+1, +2, ... modulo NUM_TOF.
    - On a grant: ToF_Index<=g, last_grant<=g, go to SELECT.
    - Otherwise remain in IDLE.
  - SELECT (one cycle; data_in now reflects g):
    - Register addra<={g, data_in zone}, dina<=data_in[DATA_W-1:0], wea<=1.
    - Clear pending[g] (clr[g]=1). Go to WRITE.
  - WRITE:
    - wea is high during this cycle; wea<=0 at its end. Go to IDLE.
- Timing:
  - Latency: ToF_dr pulse in cycle C leads to wea=1 in cycle C+3 when the arbiter is idle and en=1.
  - Throughput: one write per 3 cycles.
- en deasserted:
  - Only blocks the IDLE->SELECT transition.
  - A grant already in progress completes.
- ToF_Index holds its last value while idle.
- Frame tracking:
  - In SELECT, if data_in zone==LAST_ZONE, done_mask[g]<=1.
  - When done_mask becomes all-ones: frame_done=1 for exactly one cycle (the WRITE cycle) and done_mask<=0 on that same edge.
  - A repeated LAST_ZONE from a sensor before the frame completes is harmless (bit already set).
- Zone address is taken verbatim from data_in; no range checking. ToF_Index is a 3-bit value and wraps 7->0 in the round-robin search.

Test Plan:
- Reset then single request: hold reset=0 for 2 cycles, release, en=1; pulse ToF_dr=8'b0000_0100 with data_in zone=5, value 0x1234 -> wea=1 exactly 3 cycles after the pulse, addra=9'b010_000101, dina=0x1234, ToF_Index=2, busy high for 2 cycles.
- Fairness: pulse ToF_dr=8'hFF once -> exactly 8 wea pulses, ToF_Index sequence 0,1,...,7, 3 cycles apart; overrun stays 0.
- Round-robin rotation: with last_grant=3, pulse ToF_dr bits 1 and 5 simultaneously -> grant 5 first, then 1.
- Overrun: pulse ToF_dr[4] twice 1 cycle apart with en=0 -> overrun=8'h10; clear_overrun -> overrun=0; set-vs-clear collision in the SELECT cycle -> pending stays set, second write follows.
- Frame done: each sensor 0..7 delivers zone 63 (sensor 3 twice) -> single frame_done pulse coincident with the 8th distinct sensor's wea; done_mask cleared; next frame is counted from zero.
- Reset mid-operation: assert reset during the SELECT cycle -> no wea, all outputs back to reset values on the next edge, pending cleared.

Source files
------------

// File: rtl/tof_bram_write_arbiter.sv
// Round-robin arbiter that shares the single ToF BRAM write port among the ToF sensor channels.
// Each grant selects the sensor's muxed I2C data, then issues one write at {ToF_Index, zone}.
module tof_bram_write_arbiter #(
    parameter int NUM_TOF   = 8,
    parameter int IDX_W     = 3,
    parameter int ZONE_W    = 6,
    parameter int DATA_W    = 16,
    parameter int LAST_ZONE = 63
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic [NUM_TOF-1:0]        ToF_dr,
    input  logic [ZONE_W+DATA_W-1:0]  data_in,
    input  logic                      clear_overrun,
    output logic [IDX_W-1:0]          ToF_Index,
    output logic                      wea,
    output logic [IDX_W+ZONE_W-1:0]   addra,
    output logic [DATA_W-1:0]         dina,
    output logic                      busy,
    output logic [NUM_TOF-1:0]        overrun,
    output logic                      frame_done
);

    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_WRITE} state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [NUM_TOF-1:0]        r_pending;
    logic [NUM_TOF-1:0]        r_done_mask;
    logic [NUM_TOF-1:0]        r_overrun;
    logic [IDX_W-1:0]          r_tof_index;
    logic [IDX_W-1:0]          r_last_grant;
    logic [IDX_W+ZONE_W-1:0]   r_addra;
    logic [DATA_W-1:0]         r_dina;
    logic                      r_wea;
    logic                      r_frame_done;

    logic [NUM_TOF-1:0]        w_clr;
    logic [NUM_TOF-1:0]        w_ovr_evt;
    logic [NUM_TOF-1:0]        w_done_next;
    logic [IDX_W-1:0]          w_cand [NUM_TOF];
    logic [IDX_W-1:0]          w_grant;
    logic                      w_grant_valid;
    logic                      w_start;
    logic [ZONE_W-1:0]         w_zone;

    assign w_zone = data_in[DATA_W+ZONE_W-1:DATA_W];

    // Candidate k is the sensor k+1 places after the last grant; the last grant itself comes last.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_TOF; gi++) begin : g_chan
            assign w_cand[gi] = r_last_grant + IDX_W'(gi + 1);
            assign w_clr[gi]  = (r_state == S_SELECT) && (r_tof_index == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        w_grant       = '0;
        w_grant_valid = 1'b0;
        for (int k = NUM_TOF - 1; k >= 0; k--) begin
            if (r_pending[w_cand[k]]) begin
                w_grant       = w_cand[k];
                w_grant_valid = 1'b1;
            end
        end
    end

    // A new strobe on a still-pending sensor loses a sample unless this cycle retires it.
    assign w_ovr_evt   = ToF_dr & r_pending & ~w_clr;
    assign w_done_next = r_done_mask | ((w_zone == ZONE_W'(LAST_ZONE)) ? w_clr : '0);
    assign w_start     = (r_state == S_IDLE) && (w_state_next == S_SELECT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (en && w_grant_valid) w_state_next = S_SELECT;
            S_SELECT: w_state_next = S_WRITE;
            S_WRITE:  w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pending    <= '0;
            r_done_mask  <= '0;
            r_overrun    <= '0;
            r_tof_index  <= '0;
            r_last_grant <= IDX_W'(NUM_TOF - 1);
            r_addra      <= '0;
            r_dina       <= '0;
            r_wea        <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_pending    <= (r_pending & ~w_clr) | ToF_dr;
            r_overrun    <= (clear_overrun ? '0 : r_overrun) | w_ovr_evt;
            r_wea        <= 1'b0;
            r_frame_done <= 1'b0;
            if (w_start) begin
                r_tof_index  <= w_grant;
                r_last_grant <= w_grant;
            end
            if (r_state == S_SELECT) begin
                r_addra <= {r_tof_index, w_zone};
                r_dina  <= data_in[DATA_W-1:0];
                r_wea   <= 1'b1;
                if (&w_done_next) begin
                    r_frame_done <= 1'b1;
                    r_done_mask  <= '0;
                end else begin
                    r_done_mask  <= w_done_next;
                end
            end
        end
    end

    assign ToF_Index  = r_tof_index;
    assign wea        = r_wea;
    assign addra      = r_addra;
    assign dina       = r_dina;
    assign overrun    = r_overrun;
    assign frame_done = r_frame_done;

endmodule
